// File: rtl/vdp_pkg.sv
// Shared constants and types for the VDP colour path: CRAM geometry, RGB width,
// sprite palette select bit and the default active/Game Gear window geometry.
package vdp_pkg;
    localparam int CRAM_ENTRIES    = 32;
    localparam int CRAM_IDX_W      = 5;
    localparam int RGB_W           = 12;
    localparam int SPR_PALETTE_BIT = 4;

    localparam int ACTIVE_W = 256;
    localparam int ACTIVE_H = 192;
    localparam int GG_X0    = 48;
    localparam int GG_Y0    = 24;
    localparam int GG_W     = 160;
    localparam int GG_H     = 144;

    typedef logic [RGB_W-1:0]      rgb12_t;
    typedef logic [CRAM_IDX_W-1:0] cram_idx_t;
endpackage

// File: rtl/vdp_color_mixer_if.sv
// Pixel, CPU CRAM and video output signals of vdp_color_mixer.
// VDP_CRAM_READBACK_EN adds the CPU CRAM readback port.
interface vdp_color_mixer_if;
    import vdp_pkg::*;

    logic [9:0]          pixel_x;
    logic [9:0]          pixel_y;
    logic [CRAM_IDX_W:0] bg_color;
    logic                bg_priority;
    logic [3:0]          spr_color;
    logic [3:0]          backdrop_color;
    logic                cram_we;
    logic [CRAM_IDX_W:0] cram_addr;
    logic [7:0]          cram_wdata;
    logic [3:0]          red;
    logic [3:0]          green;
    logic [3:0]          blue;
    logic                pixel_valid;
`ifdef VDP_CRAM_READBACK_EN
    logic                cram_re;
    logic [CRAM_IDX_W:0] cram_raddr;
    logic [7:0]          cram_rdata;

    modport master (
        output pixel_x, pixel_y, bg_color, bg_priority, spr_color, backdrop_color,
        output cram_we, cram_addr, cram_wdata, cram_re, cram_raddr,
        input  red, green, blue, pixel_valid, cram_rdata
    );
    modport slave (
        input  pixel_x, pixel_y, bg_color, bg_priority, spr_color, backdrop_color,
        input  cram_we, cram_addr, cram_wdata, cram_re, cram_raddr,
        output red, green, blue, pixel_valid, cram_rdata
    );
`else
    modport master (
        output pixel_x, pixel_y, bg_color, bg_priority, spr_color, backdrop_color,
        output cram_we, cram_addr, cram_wdata,
        input  red, green, blue, pixel_valid
    );
    modport slave (
        input  pixel_x, pixel_y, bg_color, bg_priority, spr_color, backdrop_color,
        input  cram_we, cram_addr, cram_wdata,
        output red, green, blue, pixel_valid
    );
`endif
endinterface

// File: rtl/vdp_cram.sv
// Colour RAM: 32 x 12-bit {B,G,R} entries, CPU even/odd byte latch, pixel read port.
// VDP_CRAM_READBACK_EN adds a registered CPU byte readback port.
module vdp_cram
    import vdp_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cram_we,
    input  logic [CRAM_IDX_W:0] cram_addr,
    input  logic [7:0]          cram_wdata,
    input  cram_idx_t           rd_idx,
    output rgb12_t              rd_rgb
`ifdef VDP_CRAM_READBACK_EN
    ,
    input  logic                cram_re,
    input  logic [CRAM_IDX_W:0] cram_raddr,
    output logic [7:0]          cram_rdata
`endif
);
    rgb12_t     mem [CRAM_ENTRIES];
    logic [7:0] latch;

    // Even byte only loads the latch; the odd byte commits {B, latched G/R}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch <= '0;
            for (int i = 0; i < CRAM_ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else if (cram_we) begin
            if (cram_addr[0]) begin
                mem[cram_addr[CRAM_IDX_W:1]] <= {cram_wdata[3:0], latch};
            end else begin
                latch <= cram_wdata;
            end
        end
    end

    // Combinational read; the caller registers it, so a same-edge write is not seen.
    assign rd_rgb = mem[rd_idx];

`ifdef VDP_CRAM_READBACK_EN
    rgb12_t rb_word;
    assign rb_word = mem[cram_raddr[CRAM_IDX_W:1]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cram_rdata <= '0;
        end else if (cram_re) begin
            cram_rdata <= cram_raddr[0] ? {4'h0, rb_word[11:8]} : rb_word[7:0];
        end
    end
`endif
endmodule

// File: rtl/vdp_color_mixer.sv
// Background/sprite priority mix, window classification and CRAM lookup, 2-clock latency.
// VDP_CRAM_READBACK_EN exposes the CRAM readback port through the bus interface.
module vdp_color_mixer #(
    parameter int ACTIVE_W = vdp_pkg::ACTIVE_W,
    parameter int ACTIVE_H = vdp_pkg::ACTIVE_H,
    parameter int GG_X0    = vdp_pkg::GG_X0,
    parameter int GG_Y0    = vdp_pkg::GG_Y0,
    parameter int GG_W     = vdp_pkg::GG_W,
    parameter int GG_H     = vdp_pkg::GG_H
) (
    input logic               clk,
    input logic               rst_n,
    vdp_color_mixer_if.slave  bus
);
    import vdp_pkg::*;

    localparam logic [9:0] X_ACT = 10'(ACTIVE_W);
    localparam logic [9:0] Y_ACT = 10'(ACTIVE_H);
    localparam logic [9:0] GX_LO = 10'(GG_X0);
    localparam logic [9:0] GX_HI = 10'(GG_X0 + GG_W - 1);
    localparam logic [9:0] GY_LO = 10'(GG_Y0);
    localparam logic [9:0] GY_HI = 10'(GG_Y0 + GG_H - 1);
    localparam cram_idx_t  UPPER_PAL = cram_idx_t'(1 << SPR_PALETTE_BIT);

    cram_idx_t bg_idx;
    logic      bg_opaque;
    logic      in_active_d, in_gg_d;
    cram_idx_t sel_d, sel_q;
    logic      in_active_q, in_gg_q;
    rgb12_t    rd_rgb, rgb_q;
    logic      valid_q;
    logic      unused_bg_lsb;

    assign unused_bg_lsb = bus.bg_color[0];

    always_comb begin
        bg_idx      = bus.bg_color[CRAM_IDX_W:1];
        bg_opaque   = |bg_idx[3:0];
        in_active_d = (bus.pixel_x < X_ACT) && (bus.pixel_y < Y_ACT);
        in_gg_d     = (bus.pixel_x >= GX_LO) && (bus.pixel_x <= GX_HI) &&
                      (bus.pixel_y >= GY_LO) && (bus.pixel_y <= GY_HI);
        // Active area outside the Game Gear window shows the backdrop colour.
        if (in_active_d && !in_gg_d) begin
            sel_d = UPPER_PAL | cram_idx_t'(bus.backdrop_color);
        end else if ((bus.spr_color != 4'h0) && !(bus.bg_priority && bg_opaque)) begin
            sel_d = UPPER_PAL | cram_idx_t'(bus.spr_color);
        end else begin
            sel_d = bg_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q       <= '0;
            in_active_q <= 1'b0;
            in_gg_q     <= 1'b0;
            rgb_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            in_active_q <= in_active_d;
            in_gg_q     <= in_gg_d;
            rgb_q       <= in_active_q ? rd_rgb : '0;
            valid_q     <= in_gg_q;
        end
    end

    vdp_cram u_cram (
        .clk        (clk),
        .rst_n      (rst_n),
        .cram_we    (bus.cram_we),
        .cram_addr  (bus.cram_addr),
        .cram_wdata (bus.cram_wdata),
        .rd_idx     (sel_q),
        .rd_rgb     (rd_rgb)
`ifdef VDP_CRAM_READBACK_EN
        ,
        .cram_re    (bus.cram_re),
        .cram_raddr (bus.cram_raddr),
        .cram_rdata (bus.cram_rdata)
`endif
    );

    assign bus.red         = rgb_q[3:0];
    assign bus.green       = rgb_q[7:4];
    assign bus.blue        = rgb_q[11:8];
    assign bus.pixel_valid = valid_q;
endmodule

// File: doc/vdp_color_mixer.md
Name: vdp_color_mixer

Overview:
Downstream of vdp_background and the sprite engine. Each clock it resolves background against sprite priority and looks up the winning colour in CRAM. It outputs 12-bit Game Gear RGB to the video encoder. It also owns the CRAM storage and the CPU-side CRAM write path, including the even/odd byte latch.

Parameters:
ACTIVE_W, 256, active display width in pixels
ACTIVE_H, 192, active display height in lines
GG_X0, 48, first visible Game Gear column
GG_Y0, 24, first visible Game Gear line
GG_W, 160, Game Gear window width
GG_H, 144, Game Gear window height

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
pixel_x  in  10  column of the pixel presented this cycle (aligned with bg_color)
pixel_y  in  10  line of the pixel presented this cycle
bg_color  in  6  background CRAM byte address from vdp_background (bit0 always 0, bit5 = palette)
bg_priority  in  1  background tile priority
spr_color  in  4  sprite pixel index, 0 = transparent (sprites always use upper palette)
backdrop_color  in  4  backdrop index into upper palette (VDP reg 7)
cram_we  in  1  CPU CRAM write strobe, one cycle
cram_addr  in  6  CPU CRAM byte address
cram_wdata  in  8  CPU CRAM write data
red  out  4  pixel red
green  out  4  pixel green
blue  out  4  pixel blue
pixel_valid  out  1  output pixel is inside the GG window

Behaviour:
- CRAM: 32 entries x 12 bits {B[3:0],G[3:0],R[3:0]}; all entries cleared at reset.
- CPU write, even cram_addr: store cram_wdata in the 8-bit latch; CRAM unchanged.
- CPU write, odd cram_addr: entry cram_addr[5:1] <= {cram_wdata[3:0], latch}. Latch G/R = latch[7:4]/[3:0]. The latch is not cleared afterwards.
- Consecutive odd writes reuse the same latch value.
- Latch resets to 0.
- Stage 1 (registered), mix:
  - bg_idx = bg_color[5:1].
  - bg_opaque = bg_idx[3:0] != 0.
  - If spr_color != 0 and !(bg_priority && bg_opaque), then sel = {1'b1, spr_color}; else sel = bg_idx.
  - Background index 0 is still drawn from CRAM (no backdrop substitution inside the active area).
  - in_active = pixel_x < ACTIVE_W && pixel_y < ACTIVE_H.
  - in_gg = pixel_x in [GG_X0, GG_X0+GG_W-1] && pixel_y in [GG_Y0, GG_Y0+GG_H-1]; both flags are registered alongside sel.
  - For active pixels outside the GG window, sel = {1'b1, backdrop_color}.
- Stage 2 (registered), lookup:
  - rgb <= CRAM[sel_q] when in_active_q, else 12'h000.
  - pixel_valid <= in_gg_q.
- Latency: exactly 2 clocks from pixel_x/pixel_y/colour inputs to red/green/blue/pixel_valid.
- Read/write collision: a CPU write to the same entry in the cycle stage 2 reads it returns the OLD value (read-before-write). The new value is visible from the next cycle.
- Arithmetic: all window compares are unsigned on 10 bits; no wrap-around. pixel_x/y >= 1024 cannot occur.
- Reset outputs: red = green = blue = 0, pixel_valid = 0, pipeline flags 0.
- Reset mid-frame: pipeline empties immediately; output resumes 2 clocks after rst_n deasserts. CRAM must be reloaded by the CPU.

Optional Feature:
Macro: VDP_CRAM_READBACK_EN.
- Defined: adds input cram_re (1), input cram_raddr (6) and output cram_rdata (8, registered, 1-clock latency).
  - Even cram_raddr returns {G,R}; odd returns {4'h0,B}.
  - A read and a write to the same entry in the same cycle return the old data.
  - cram_rdata resets to 0 and holds its value when cram_re = 0.
- Undefined: these ports do not exist; CRAM is write-only.

Decomposition:
- Shared package vdp_pkg holds:
  - CRAM_ENTRIES = 32
  - CRAM_IDX_W = 5
  - RGB_W = 12
  - SPR_PALETTE_BIT = 4
  - ACTIVE_W/ACTIVE_H and GG window defaults
  - typedef rgb12_t
- One sub-module, vdp_cram: storage, CPU byte latch, pixel read port and the optional readback port. Mixing and window logic stay in vdp_color_mixer.

Test Plan:
- CRAM load: CPU writes addr 0x02 = 0xA5, then 0x03 = 0x0C. Present bg_color = 0x02, spr = 0, at (100,50). Two clocks later: R = 5, G = A, B = C, pixel_valid = 1.
- Priority: load entries 1, 2 and 17 (0x22/0x23) with distinct colours. Set bg_color = 0x02, spr = 1.
  - bg_priority = 0: outputs entry 17.
  - bg_priority = 1: outputs entry 1.
  - bg_priority = 1 with bg_color = 0x00: outputs entry 17.
- Window: sweep pixel_x 0..300 at pixel_y = 30. pixel_valid rises exactly at x = 48 (+2 clocks) and falls after x = 207.
  - x in [0,47]: backdrop entry 16+backdrop_color.
  - x >= 256: rgb = 0.
- Latch reuse: write 0x10 = 0x3F, then 0x11 = 0x01 and 0x13 = 0x02. Entries 8 and 9 both have G/R = 3/F, with B = 1 and 2 respectively.
- Collision: write entry 5 odd byte in the same cycle stage 2 reads entry 5. That pixel shows the old colour; the next cycle shows the new colour.
- Reset: assert rst_n low mid-line. Outputs are 0 immediately (asynchronous). Entry 1 reads 0 afterwards. With VDP_CRAM_READBACK_EN, cram_rdata = 0.
